// File: rtl/atm_session_ctrl.sv
// ATM session controller: owns one card session from insert to eject/retain.
// Latency: strobe to new state 1 cycle; op_vld to op_done/wr_en 2 cycles.
// Backpressure: none; strobes are ignored outside the state that consumes them.
// Optional build macro ATM_TXN_CNT_EN adds the txn_cnt session transaction counter.
module atm_session_ctrl #(
  parameter int BAL_W       = 20,
  parameter int TRY_MAX     = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int WD_LIMIT    = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             lang_vld,
  input  logic             lang_sel,
  input  logic             pin_vld,
  input  logic             pin_ok,
  input  logic [BAL_W-1:0] acct_balance,
  input  logic             op_vld,
  input  logic [1:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic             another_vld,
  input  logic             another,
  input  logic             cancel,
  output logic [3:0]       state,
  output logic             lang,
  output logic [BAL_W-1:0] balance,
  output logic             op_done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic             wr_en,
  output logic [BAL_W-1:0] wr_balance,
  output logic             card_out,
  output logic             card_retain
`ifdef ATM_TXN_CNT_EN
  ,
  output logic [7:0]       txn_cnt
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] OP_WD  = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_INQ = 2'b10;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PIN   = 3'd1;
  localparam logic [2:0] E_FUNDS = 3'd2;
  localparam logic [2:0] E_LIMIT = 3'd3;
  localparam logic [2:0] E_OVF   = 3'd4;
  localparam logic [2:0] E_ZERO  = 3'd5;
  localparam logic [2:0] E_TMO   = 3'd6;
  localparam logic [2:0] E_RET   = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LANG    = 4'd1,
    S_PIN     = 4'd2,
    S_MENU    = 4'd3,
    S_WDRAW   = 4'd4,
    S_DEPOSIT = 4'd5,
    S_INQUIRY = 4'd6,
    S_ANOTHER = 4'd7,
    S_EJECT   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic               lang_d;
  logic [BAL_W-1:0]   bal_d;
  logic [2:0]         tries_q, tries_d, tries_inc;
  logic [BAL_W-1:0]   wd_sum_q, wd_sum_d;
  logic [1:0]         op_q, op_d;
  logic [BAL_W-1:0]   amt_q, amt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               retain_q, retain_d;
  logic [2:0]         err_code_d;
  logic               op_done_d, error_d, wr_en_d, card_out_d, card_retain_d;
  logic [BAL_W-1:0]   wr_bal_d;
  logic [BAL_W:0]     sum_dep, sum_wd;
  logic               counted, timer_hit, retain_evt, strobe_acc;

  assign state = state_q;

  // Next-state, datapath updates and output pulses for the session FSM.
  always_comb begin
    state_d       = state_q;
    lang_d        = lang;
    bal_d         = balance;
    tries_d       = tries_q;
    wd_sum_d      = wd_sum_q;
    op_d          = op_q;
    amt_d         = amt_q;
    retain_d      = retain_q;
    err_code_d    = err_code;
    wr_bal_d      = wr_balance;
    op_done_d     = 1'b0;
    error_d       = 1'b0;
    wr_en_d       = 1'b0;
    card_out_d    = 1'b0;
    card_retain_d = 1'b0;
    strobe_acc    = 1'b0;

    // Carry-out bit of each sum flags overflow / limit excess.
    sum_dep    = {1'b0, balance} + {1'b0, amt_q};
    sum_wd     = {1'b0, wd_sum_q} + {1'b0, amt_q};
    tries_inc  = tries_q + 3'd1;
    counted    = (state_q == S_LANG) || (state_q == S_PIN) ||
                 (state_q == S_MENU) || (state_q == S_ANOTHER);
    timer_hit  = counted && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
    // Final wrong PIN: retention must survive a simultaneous cancel.
    retain_evt = (state_q == S_PIN) && pin_vld && !pin_ok &&
                 (tries_inc == 3'(TRY_MAX));

    if (state_q == S_IDLE) begin
      err_code_d = E_NONE;
      if (card_in) begin
        state_d    = S_LANG;
        strobe_acc = 1'b1;
      end
    end else if (state_q == S_EJECT) begin
      card_retain_d = retain_q;
      card_out_d    = !retain_q;
      bal_d         = '0;
      wd_sum_d      = '0;
      tries_d       = 3'd0;
      lang_d        = 1'b0;
      retain_d      = 1'b0;
      err_code_d    = E_NONE;
      state_d       = S_IDLE;
    end else if (cancel && !retain_evt) begin
      retain_d = 1'b0;
      state_d  = S_EJECT;
    end else if (timer_hit) begin
      error_d    = 1'b1;
      err_code_d = E_TMO;
      retain_d   = 1'b0;
      state_d    = S_EJECT;
    end else begin
      case (state_q)
        S_LANG: begin
          if (lang_vld) begin
            lang_d     = lang_sel;
            strobe_acc = 1'b1;
            state_d    = S_PIN;
          end
        end
        S_PIN: begin
          if (pin_vld) begin
            strobe_acc = 1'b1;
            if (pin_ok) begin
              bal_d   = acct_balance;
              tries_d = 3'd0;
              state_d = S_MENU;
            end else begin
              tries_d = tries_inc;
              error_d = 1'b1;
              if (retain_evt) begin
                err_code_d = E_RET;
                retain_d   = 1'b1;
                state_d    = S_EJECT;
              end else begin
                err_code_d = E_PIN;
              end
            end
          end
        end
        S_MENU: begin
          if (op_vld && (op != 2'b11)) begin
            op_d       = op;
            amt_d      = amount;
            strobe_acc = 1'b1;
            if (op == OP_WD)       state_d = S_WDRAW;
            else if (op == OP_DEP) state_d = S_DEPOSIT;
            else                   state_d = S_INQUIRY;
          end
        end
        S_WDRAW, S_DEPOSIT: begin
          // Default to the error exit; the success arms override it.
          state_d = S_MENU;
          if (amt_q == '0) begin
            error_d    = 1'b1;
            err_code_d = E_ZERO;
          end else if (op_q == OP_WD) begin
            if (amt_q > balance) begin
              error_d    = 1'b1;
              err_code_d = E_FUNDS;
            end else if (sum_wd > (BAL_W+1)'(WD_LIMIT)) begin
              error_d    = 1'b1;
              err_code_d = E_LIMIT;
            end else begin
              bal_d     = balance - amt_q;
              wd_sum_d  = sum_wd[BAL_W-1:0];
              wr_bal_d  = balance - amt_q;
              op_done_d = 1'b1;
              wr_en_d   = 1'b1;
              state_d   = S_ANOTHER;
            end
          end else begin
            if (sum_dep[BAL_W]) begin
              error_d    = 1'b1;
              err_code_d = E_OVF;
            end else begin
              bal_d     = sum_dep[BAL_W-1:0];
              wr_bal_d  = sum_dep[BAL_W-1:0];
              op_done_d = 1'b1;
              wr_en_d   = 1'b1;
              state_d   = S_ANOTHER;
            end
          end
        end
        S_INQUIRY: begin
          op_done_d = (op_q == OP_INQ);
          state_d   = S_ANOTHER;
        end
        S_ANOTHER: begin
          if (another_vld) begin
            strobe_acc = 1'b1;
            state_d    = another ? S_MENU : S_EJECT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Inactivity timer restarts on any progress, runs only while waiting on the user.
    if ((state_d != state_q) || strobe_acc) tmr_d = '0;
    else if (counted)                       tmr_d = tmr_q + TMR_W'(1);
    else                                    tmr_d = '0;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lang        <= 1'b0;
      balance     <= '0;
      tries_q     <= 3'd0;
      wd_sum_q    <= '0;
      op_q        <= 2'b00;
      amt_q       <= '0;
      tmr_q       <= '0;
      retain_q    <= 1'b0;
      err_code    <= E_NONE;
      op_done     <= 1'b0;
      error       <= 1'b0;
      wr_en       <= 1'b0;
      wr_balance  <= '0;
      card_out    <= 1'b0;
      card_retain <= 1'b0;
    end else begin
      state_q     <= state_d;
      lang        <= lang_d;
      balance     <= bal_d;
      tries_q     <= tries_d;
      wd_sum_q    <= wd_sum_d;
      op_q        <= op_d;
      amt_q       <= amt_d;
      tmr_q       <= tmr_d;
      retain_q    <= retain_d;
      err_code    <= err_code_d;
      op_done     <= op_done_d;
      error       <= error_d;
      wr_en       <= wr_en_d;
      wr_balance  <= wr_bal_d;
      card_out    <= card_out_d;
      card_retain <= card_retain_d;
    end
  end

`ifdef ATM_TXN_CNT_EN
  // Successful operations in this session, saturating, dropped at eject.
  always_ff @(posedge clk) begin
    if (rst)                              txn_cnt <= 8'd0;
    else if (state_q == S_EJECT)          txn_cnt <= 8'd0;
    else if (op_done_d && txn_cnt != 8'hFF) txn_cnt <= txn_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Parametrised ATM session controller; next generation of the bank-system FSM.
- Owns one card session end to end: card insert, language, PIN retries, operation menu, withdraw/deposit/inquiry, repeat-service, eject or retain.
- Adds an internal inactivity timer, a per-session withdrawal limit, overflow-checked arithmetic, coded errors and a balance write-back port toward the account store.

Parameters:
- BAL_W, 20, balance/amount width in bits.
- TRY_MAX, 3, wrong PINs allowed before card retention (1..7).
- TIMEOUT_CYC, 1000, idle cycles before a session is aborted (>=2); timer width is $clog2(TIMEOUT_CYC).
- WD_LIMIT, 5000, maximum total withdrawn per session.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset.
- card_in  in  1  card inserted pulse; IDLE only.
- lang_vld  in  1  language selection strobe.
- lang_sel  in  1  1 = Arabic, 0 = English.
- pin_vld  in  1  PIN check result strobe.
- pin_ok  in  1  PIN correct; qualified by pin_vld.
- acct_balance  in  BAL_W  stored balance; sampled when pin_vld && pin_ok.
- op_vld  in  1  operation request strobe; MENU only.
- op  in  2  00 withdraw, 01 deposit, 10 inquiry, 11 reserved.
- amount  in  BAL_W  operand; sampled with op_vld.
- another_vld  in  1  repeat-service answer strobe.
- another  in  1  1 = return to MENU, 0 = end session.
- cancel  in  1  user abort, any non-IDLE state.
- state  out  4  current state encoding.
- lang  out  1  registered language.
- balance  out  BAL_W  session balance.
- op_done  out  1  one-cycle success pulse.
- error  out  1  one-cycle error pulse.
- err_code  out  3  held until next error or session end: 0 none, 1 bad PIN, 2 insufficient, 3 limit, 4 overflow, 5 zero amount, 6 timeout, 7 retained.
- wr_en  out  1  one-cycle write-back strobe.
- wr_balance  out  BAL_W  new balance; valid with wr_en.
- card_out  out  1  one-cycle eject pulse.
- card_retain  out  1  one-cycle retain pulse.

Behaviour:
- Reset: one clock, synchronous, active-high; rst wins over every input. State goes to IDLE. All outputs, the timer, the try counter, the withdrawn sum and the latched amount/op go to 0. A reset mid-session drops the session with no card_out, no card_retain and no wr_en.
- State encodings: IDLE 0, LANG 1, PIN 2, MENU 3, WDRAW 4, DEPOSIT 5, INQUIRY 6, ANOTHER 7, EJECT 8.
- Input priority, every cycle: cancel > timeout > valid strobe.
- IDLE: card_in -> LANG. All other inputs ignored.
- LANG: lang_vld latches lang -> PIN.
- PIN, pin_vld with pin_ok: latch acct_balance into balance, clear tries -> MENU.
- PIN, pin_vld without pin_ok: tries++, error=1, err_code=1.
  - tries reaching TRY_MAX -> EJECT with retain flag and err_code 7.
  - Otherwise stay in PIN.
- MENU, op_vld: latch op and amount. 00 -> WDRAW, 01 -> DEPOSIT, 10 -> INQUIRY. 11 ignored; stays in MENU, no error.
- WDRAW: one cycle, checks in this order:
  - amount==0 -> err 5.
  - amount>balance -> err 2.
  - wd_sum+amount>WD_LIMIT (computed at BAL_W+1 bits) -> err 3.
  - Otherwise balance-=amount, wd_sum+=amount, op_done=1, wr_en=1, wr_balance=new balance -> ANOTHER.
- DEPOSIT: one cycle:
  - amount==0 -> err 5.
  - BAL_W+1-bit sum carry set -> err 4; no saturation, balance unchanged.
  - Otherwise balance+=amount, op_done=1, wr_en=1 -> ANOTHER.
- Any WDRAW/DEPOSIT error: error=1, balance unchanged, no wr_en -> MENU. Operation errors never count as PIN tries.
- INQUIRY: one cycle, op_done=1, no wr_en -> ANOTHER.
- ANOTHER: another_vld with another=1 -> MENU; with another=0 -> EJECT.
- EJECT: one cycle. Pulse card_retain if the retain flag is set, else card_out. Clear balance, wd_sum, tries and lang -> IDLE. err_code is kept through EJECT, cleared on the IDLE entry cycle.
- Timer:
  - Counts in LANG, PIN, MENU and ANOTHER.
  - Clears on any state change or accepted strobe.
  - Reaching TIMEOUT_CYC-1 -> error=1, err_code=6 -> EJECT with normal eject.
- cancel in a non-IDLE state -> EJECT, normal eject, no error. Exception: cancel in the retain cycle of PIN does not override retention.
- Latency: strobe to new state is 1 cycle. op_vld to op_done/wr_en is 2 cycles (MENU accept, then the execution state).

Optional Feature:
- Macro ATM_TXN_CNT_EN.
- Defined: adds output txn_cnt [7:0]. It counts op_done pulses in the current session, saturates at 255, clears in EJECT and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- card_in, lang_vld lang_sel=1, pin_ok with acct_balance=1000, withdraw 300, another=0 -> op_done and wr_en with wr_balance=700; card_out 1 cycle later; balance back to 0.
- Three wrong PINs (TRY_MAX=3) -> error each time; err_code=1, 1, then 7; card_retain pulse; no card_out; back to IDLE.
- balance=1000, WD_LIMIT=5000, withdraw 0 -> err 5; withdraw 1200 -> err 2. Then balance=6000: withdraw 4000, then 1500 -> err 3, balance stays 2000.
- BAL_W=20, balance=1048000, deposit 1000 -> err 4, no wr_en. Deposit 575 -> balance=1048575, wr_en.
- Wait in MENU with no input for TIMEOUT_CYC cycles -> err_code=6 and EJECT on the cycle the timer hits TIMEOUT_CYC-1. Separately, cancel asserted in the same cycle as op_vld -> EJECT with no op_done.
- Assert rst during WDRAW -> next cycle IDLE with all outputs 0 and no wr_en. With ATM_TXN_CNT_EN, three inquiries -> txn_cnt=3, cleared after eject.
